snitch_icache_refill_writer: RTL and testbench

SNITCH_ICACHE_REFILL_WRITER -- requirements
Module: snitch_icache_refill_writer

---
 rtl/snitch_icache_refill_writer.sv | 163 ++++++++++++++++
 tb/tb_snitch_icache_refill_writer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_refill_writer.sv
// Instruction-cache refill writer: fetches one line per miss, assembles the beats
// and hands the line to both the cache array and the requester.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a miss or flush; the only state accepting either
// REQ    | refill request for the line-aligned address is outstanding
// RECV   | collecting response beats into the line buffer
// DONE   | cache write and requester response pending until both accepted
module snitch_icache_refill_writer #(
  parameter int unsigned FETCH_AW   = 32,
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned LINE_COUNT = 32,
  parameter int unsigned SET_COUNT  = 2,
  parameter int unsigned ID_WIDTH   = 4,
  localparam int unsigned BEATS       = LINE_WIDTH / BEAT_WIDTH,
  localparam int unsigned COUNT_ALIGN = $clog2(LINE_COUNT),
  localparam int unsigned SET_ALIGN   = (SET_COUNT > 1) ? $clog2(SET_COUNT) : 1,
  localparam int unsigned LINE_ALIGN  = $clog2(LINE_WIDTH / 8),
  localparam int unsigned TAG_WIDTH   = FETCH_AW - LINE_ALIGN - COUNT_ALIGN
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_valid_i,
  output logic                   flush_ready_o,
  input  logic [FETCH_AW-1:0]    miss_addr_i,
  input  logic [ID_WIDTH-1:0]    miss_id_i,
  input  logic                   miss_valid_i,
  output logic                   miss_ready_o,
  output logic [FETCH_AW-1:0]    refill_addr_o,
  output logic                   refill_valid_o,
  input  logic                   refill_ready_i,
  input  logic [BEAT_WIDTH-1:0]  refill_data_i,
  input  logic                   refill_error_i,
  input  logic                   refill_rvalid_i,
  output logic                   refill_rready_o,
  output logic [COUNT_ALIGN-1:0] write_addr_o,
  output logic [SET_ALIGN-1:0]   write_set_o,
  output logic [LINE_WIDTH-1:0]  write_data_o,
  output logic [TAG_WIDTH-1:0]   write_tag_o,
  output logic                   write_error_o,
  output logic                   write_valid_o,
  input  logic                   write_ready_i,
  output logic [LINE_WIDTH-1:0]  rsp_data_o,
  output logic                   rsp_error_o,
  output logic [ID_WIDTH-1:0]    rsp_id_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i
);

  localparam int unsigned BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [FETCH_AW-1:0] ADDR_MASK = ~FETCH_AW'(LINE_WIDTH / 8 - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RECV, S_DONE} state_e;

  state_e                r_state;
  logic [FETCH_AW-1:0]   r_addr;
  logic [ID_WIDTH-1:0]   r_id;
  logic [LINE_WIDTH-1:0] r_line;
  logic                  r_error;
  logic [BEAT_CW-1:0]    r_beat;
  logic [SET_ALIGN-1:0]  r_victim;
  logic                  r_write_pend;
  logic                  r_rsp_pend;

  logic w_idle;
  logic w_miss_hs;
  logic w_flush_hs;
  logic w_write_hs;
  logic w_last_beat;
  logic w_write_left;
  logic w_rsp_left;

  assign w_idle       = (r_state == S_IDLE);
  assign w_flush_hs   = w_idle && flush_valid_i;
  assign w_miss_hs    = miss_valid_i && miss_ready_o;
  assign w_write_hs   = r_write_pend && write_ready_i;
  assign w_last_beat  = (r_beat == BEAT_CW'(BEATS - 1));
  assign w_write_left = r_write_pend && !write_ready_i;
  assign w_rsp_left   = r_rsp_pend && !rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_id         <= '0;
      r_line       <= '0;
      r_error      <= 1'b0;
      r_beat       <= '0;
      r_write_pend <= 1'b0;
      r_rsp_pend   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss_hs) begin
            r_addr  <= miss_addr_i;
            r_id    <= miss_id_i;
            r_beat  <= '0;
            r_error <= 1'b0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (refill_ready_i) r_state <= S_RECV;
        end
        S_RECV: begin
          if (refill_rvalid_i) begin
            r_error <= r_error | refill_error_i;
            for (int k = 0; k < BEATS; k++) begin
              if (r_beat == BEAT_CW'(k)) r_line[k*BEAT_WIDTH +: BEAT_WIDTH] <= refill_data_i;
            end
            if (w_last_beat) begin
              r_beat       <= '0;
              r_write_pend <= 1'b1;
              r_rsp_pend   <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        S_DONE: begin
          // Write and response retire independently; leave once neither is outstanding.
          if (write_ready_i) r_write_pend <= 1'b0;
          if (rsp_ready_i)   r_rsp_pend   <= 1'b0;
          if (!w_write_left && !w_rsp_left) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_victim <= '0;
    end else if (w_flush_hs) begin
      r_victim <= '0;
    end else if (w_write_hs && (SET_COUNT > 1)) begin
      r_victim <= (r_victim == SET_ALIGN'(SET_COUNT - 1)) ? '0 : r_victim + 1'b1;
    end
  end

  // Flush wins over a simultaneous miss, hence the flush term in miss_ready_o.
  assign flush_ready_o   = w_idle;
  assign miss_ready_o    = w_idle && !flush_valid_i;
  assign refill_valid_o  = (r_state == S_REQ);
  assign refill_addr_o   = r_addr & ADDR_MASK;
  assign refill_rready_o = (r_state == S_RECV);

  assign write_valid_o = r_write_pend;
  assign write_addr_o  = r_addr[LINE_ALIGN +: COUNT_ALIGN];
  assign write_tag_o   = r_addr[FETCH_AW-1 -: TAG_WIDTH];
  assign write_set_o   = r_victim;
  assign write_data_o  = r_line;
  assign write_error_o = r_error;

  assign rsp_valid_o = r_rsp_pend;
  assign rsp_data_o  = r_line;
  assign rsp_error_o = r_error;
  assign rsp_id_o    = r_id;

endmodule

// File: tb/tb_snitch_icache_refill_writer.sv
// Self-checking bench for the refill writer: directed scenarios with literal
// expectations plus randomized misses checked every cycle against a line-level model.
module tb_snitch_icache_refill_writer;

  localparam int BEATS       = 2;
  localparam int BEAT_W      = 64;
  localparam int LINE_W      = 128;
  localparam int LINE_ALIGN  = 4;
  localparam int COUNT_ALIGN = 5;
  localparam int LINE_COUNT  = 32;
  localparam int SET_COUNT   = 2;

  logic          clk_i, rst_ni;
  logic          flush_valid_i, flush_ready_o;
  logic [31:0]   miss_addr_i;
  logic [3:0]    miss_id_i;
  logic          miss_valid_i, miss_ready_o;
  logic [31:0]   refill_addr_o;
  logic          refill_valid_o, refill_ready_i;
  logic [63:0]   refill_data_i;
  logic          refill_error_i, refill_rvalid_i, refill_rready_o;
  logic [4:0]    write_addr_o;
  logic [0:0]    write_set_o;
  logic [127:0]  write_data_o;
  logic [22:0]   write_tag_o;
  logic          write_error_o, write_valid_o, write_ready_i;
  logic [127:0]  rsp_data_o;
  logic          rsp_error_o;
  logic [3:0]    rsp_id_o;
  logic          rsp_valid_o, rsp_ready_i;

  snitch_icache_refill_writer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
    .miss_addr_i(miss_addr_i), .miss_id_i(miss_id_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .refill_addr_o(refill_addr_o), .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_data_i(refill_data_i), .refill_error_i(refill_error_i),
    .refill_rvalid_i(refill_rvalid_i), .refill_rready_o(refill_rready_o),
    .write_addr_o(write_addr_o), .write_set_o(write_set_o), .write_data_o(write_data_o),
    .write_tag_o(write_tag_o), .write_error_o(write_error_o),
    .write_valid_o(write_valid_o), .write_ready_i(write_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o), .rsp_id_o(rsp_id_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected transaction, written by the stimulus process.
  logic [31:0]  exp_addr;
  logic [3:0]   exp_id;
  logic [127:0] exp_line;
  logic         exp_err;
  logic [63:0]  tb_beats [BEATS];
  logic         tb_errs  [BEATS];

  // Model state, owned by the compare process.
  bit m_wpend, m_rpend;
  int m_beats, m_set;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_wpend = 0; m_rpend = 0; m_beats = 0; m_set = 0;
    end else begin
      chk("write_valid", write_valid_o, m_wpend);
      chk("rsp_valid", rsp_valid_o, m_rpend);
      if (write_valid_o) begin
        chk("write_addr", write_addr_o, (exp_addr >> LINE_ALIGN) % LINE_COUNT);
        chk("write_tag", write_tag_o, exp_addr >> (LINE_ALIGN + COUNT_ALIGN));
        chk("write_data", write_data_o, exp_line);
        chk("write_error", write_error_o, exp_err);
        chk("write_set", write_set_o, m_set);
      end
      if (rsp_valid_o) begin
        chk("rsp_data", rsp_data_o, exp_line);
        chk("rsp_error", rsp_error_o, exp_err);
        chk("rsp_id", rsp_id_o, exp_id);
      end
      if (refill_valid_o) chk("refill_addr", refill_addr_o, exp_addr - (exp_addr % (LINE_W / 8)));
      if (write_valid_o && write_ready_i) begin m_wpend = 0; m_set = (m_set + 1) % SET_COUNT; end
      if (rsp_valid_o && rsp_ready_i) m_rpend = 0;
      if (flush_valid_i && flush_ready_o) m_set = 0;
      if (refill_rvalid_i && refill_rready_o) begin
        m_beats++;
        if (m_beats == BEATS) begin m_beats = 0; m_wpend = 1; m_rpend = 1; end
      end
    end
  end

  // Captured at the first cycle each output appears, for literal checks.
  logic [31:0]  cap_refill_addr;
  logic [4:0]   cap_waddr;
  logic [22:0]  cap_tag;
  logic [127:0] cap_wdata;
  logic [0:0]   cap_set;
  logic         cap_werr, cap_rerr;
  logic [3:0]   cap_rid;
  int           cap_wcyc, cap_wdone, cap_rdone;

  task automatic accept_miss(input logic [31:0] a, input logic [3:0] id);
    int n = 0;
    bit hs = 0;
    miss_addr_i = a; miss_id_i = id; miss_valid_i = 1'b1;
    while (!hs && n < 50) begin
      @(negedge clk_i); hs = miss_ready_o;
      @(posedge clk_i); #1; n++;
    end
    miss_valid_i = 1'b0;
    chk("miss_accept", hs, 1'b1);
    exp_addr = a; exp_id = id; exp_line = '0; exp_err = 1'b0;
  endtask

  task automatic send_beat(input int k, input int gap);
    repeat (gap) begin @(posedge clk_i); #1; end
    refill_rvalid_i = 1'b1; refill_data_i = tb_beats[k]; refill_error_i = tb_errs[k];
    exp_line[k*BEAT_W +: BEAT_W] = tb_beats[k];
    exp_err = exp_err | tb_errs[k];
    @(negedge clk_i); chk("beat_rready", refill_rready_o, 1'b1);
    @(posedge clk_i); #1;
    refill_rvalid_i = 1'b0; refill_error_i = 1'b0;
  endtask

  task automatic refill_request(input int rr_dly);
    int n = 0;
    bit hs = 0;
    while (!hs && n < 50) begin
      refill_ready_i = (n >= rr_dly);
      @(negedge clk_i);
      if (n == 0) begin
        chk("refill_latency", refill_valid_o, 1'b1);
        cap_refill_addr = refill_addr_o;
      end
      hs = refill_valid_o && refill_ready_i;
      @(posedge clk_i); #1; n++;
    end
    refill_ready_i = 1'b0;
    chk("refill_handshake", hs, 1'b1);
  endtask

  task automatic run_miss(input logic [31:0] a, input logic [3:0] id, input int rr_dly,
                          input int gap, input int wd, input int rd);
    int c = 0;
    bit dw = 0, dr = 0;
    accept_miss(a, id);
    refill_request(rr_dly);
    for (int k = 0; k < BEATS; k++) send_beat(k, $urandom_range(gap, 0));
    cap_wcyc = -1; cap_wdone = -1; cap_rdone = -1;
    while (!(dw && dr) && c < 100) begin
      write_ready_i = (c >= wd) && !dw;
      rsp_ready_i   = (c >= rd) && !dr;
      @(negedge clk_i);
      chk("miss_ready_busy", miss_ready_o, 1'b0);
      if (write_valid_o && cap_wcyc < 0) begin
        cap_wcyc = c; cap_waddr = write_addr_o; cap_tag = write_tag_o; cap_wdata = write_data_o;
        cap_set = write_set_o; cap_werr = write_error_o; cap_rerr = rsp_error_o; cap_rid = rsp_id_o;
      end
      if (write_valid_o && write_ready_i) begin dw = 1; cap_wdone = c; end
      if (rsp_valid_o && rsp_ready_i) begin dr = 1; cap_rdone = c; end
      @(posedge clk_i); #1; c++;
    end
    write_ready_i = 1'b0; rsp_ready_i = 1'b0;
    chk("line_complete", dw && dr, 1'b1);
    @(negedge clk_i);
    chk("back_to_idle", miss_ready_o, 1'b1);
    @(posedge clk_i); #1;
  endtask

  task automatic flush_once();
    flush_valid_i = 1'b1;
    @(negedge clk_i); chk("flush_ready", flush_ready_o, 1'b1);
    @(posedge clk_i); #1;
    flush_valid_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; flush_valid_i = 0; miss_addr_i = '0; miss_id_i = '0; miss_valid_i = 0;
    refill_ready_i = 0; refill_data_i = '0; refill_error_i = 0; refill_rvalid_i = 0;
    write_ready_i = 0; rsp_ready_i = 0;
    exp_addr = '0; exp_id = '0; exp_line = '0; exp_err = 0;

    // Reset state
    @(negedge clk_i);
    chk("rst_write_valid", write_valid_o, 1'b0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_refill_valid", refill_valid_o, 1'b0);
    chk("rst_miss_ready", miss_ready_o, 1'b1);
    chk("rst_flush_ready", flush_ready_o, 1'b1);
    chk("rst_write_set", write_set_o, 1'b0);
    @(posedge clk_i); #1; rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Reference line fill
    tb_beats[0] = 64'hAAAA_AAAA_AAAA_AAAA; tb_beats[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    tb_errs[0] = 0; tb_errs[1] = 0;
    run_miss(32'h0000_1234, 4'd3, 0, 0, 0, 0);
    chk("ref_refill_addr", cap_refill_addr, 32'h1230);
    chk("ref_write_addr", cap_waddr, 5'h03);
    chk("ref_write_tag", cap_tag, 23'h9);
    chk("ref_write_data", cap_wdata, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA});
    chk("ref_write_set", cap_set, 1'b0);
    chk("ref_rsp_id", cap_rid, 4'd3);
    chk("ref_error", {cap_werr, cap_rerr}, 2'b00);
    chk("ref_write_latency", cap_wcyc, 0);

    // Error on the second beat
    tb_beats[0] = 64'h0123_4567_89AB_CDEF; tb_beats[1] = 64'hFEDC_BA98_7654_3210;
    tb_errs[0] = 0; tb_errs[1] = 1;
    run_miss(32'h0000_5678, 4'd7, 1, 1, 0, 0);
    chk("err_write_error", cap_werr, 1'b1);
    chk("err_rsp_error", cap_rerr, 1'b1);
    tb_errs[1] = 0;

    // Victim wrap over three misses
    flush_once();
    run_miss(32'h0000_0100, 4'd1, 0, 0, 0, 0);
    chk("rr_set0", cap_set, 1'b0);
    run_miss(32'h0000_0200, 4'd2, 0, 0, 0, 0);
    chk("rr_set1", cap_set, 1'b1);
    run_miss(32'h0000_0300, 4'd3, 0, 0, 0, 0);
    chk("rr_set2", cap_set, 1'b0);

    // Write back-pressured for five cycles while response drains at once
    run_miss(32'hDEAD_BEE0, 4'd9, 0, 0, 5, 0);
    chk("bp_rsp_first", cap_rdone, 0);
    chk("bp_write_done", cap_wdone, 5);

    // Flush and miss together: flush wins, victim restarts at way 0
    flush_valid_i = 1'b1; miss_valid_i = 1'b1; miss_addr_i = 32'h0000_4440; miss_id_i = 4'd4;
    @(negedge clk_i);
    chk("prio_flush_ready", flush_ready_o, 1'b1);
    chk("prio_miss_stall", miss_ready_o, 1'b0);
    @(posedge clk_i); #1; flush_valid_i = 1'b0;
    run_miss(32'h0000_4440, 4'd4, 0, 0, 0, 0);
    chk("prio_set", cap_set, 1'b0);

    // Reset pulse after the first beat of a refill
    accept_miss(32'h0000_7770, 4'd5);
    refill_request(0);
    send_beat(0, 0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_refill_valid", refill_valid_o, 1'b0);
    chk("mid_rst_rready", refill_rready_o, 1'b0);
    chk("mid_rst_miss_ready", miss_ready_o, 1'b1);
    @(posedge clk_i); #1; rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      chk("post_rst_write_valid", write_valid_o, 1'b0);
      chk("post_rst_rsp_valid", rsp_valid_o, 1'b0);
    end
    @(posedge clk_i); #1;

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(7, 0) == 0) flush_once();
      for (int k = 0; k < BEATS; k++) begin
        tb_beats[k] = {$urandom, $urandom};
        tb_errs[k]  = ($urandom_range(3, 0) == 0);
      end
      run_miss($urandom, 4'($urandom_range(15, 0)), $urandom_range(3, 0), 2,
               $urandom_range(4, 0), $urandom_range(4, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
